enigma_stream_bridge: RTL and testbench

//  Buffered, order-preserving byte bridge between the UART RX/TX pair and the

---
 rtl/enigma_pkg.sv | 35 +++
 rtl/enigma_stream_bridge_if.sv | 31 +++
 rtl/sync_fifo.sv | 55 +++++
 rtl/enigma_stream_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_enigma_stream_bridge.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared constants, state encodings and byte classifier for the Enigma stream bridge
//   Exports: ASCII range limits, ALPHA_N, IDX_W, cipher/TX FSM state enums,
//   char_class_e and classify() which sorts a byte into upper/lower/other.
package enigma_pkg;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam logic [7:0] ASCII_a = 8'h61;
  localparam logic [7:0] ASCII_z = 8'h7A;
  localparam int         ALPHA_N = 26;
  localparam int         IDX_W   = 5;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_WAIT = 1'b1
  } cipher_state_e;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_BUSY = 1'b1
  } tx_state_e;

  typedef enum logic [1:0] {
    CLS_UPPER = 2'd0,
    CLS_LOWER = 2'd1,
    CLS_OTHER = 2'd2
  } char_class_e;

  function automatic char_class_e classify(input logic [7:0] b);
    if (b >= ASCII_A && b <= ASCII_Z) return CLS_UPPER;
    if (b >= ASCII_a && b <= ASCII_z) return CLS_LOWER;
    return CLS_OTHER;
  endfunction

endpackage

// File: rtl/enigma_stream_bridge_if.sv
// rtl/enigma_stream_bridge_if.sv - handshake bundle between bridge, UART RX/TX and cipher core
//   rx_byte/rx_valid        : UART RX -> bridge
//   core_char/core_valid    : bridge -> cipher core
//   core_result/core_res_valid : cipher core -> bridge
//   tx_byte/tx_start        : bridge -> UART TX
//   tx_done                 : UART TX -> bridge
//   slave modport is the bridge side, master modport is the environment side.
interface enigma_stream_bridge_if
  import enigma_pkg::*;
;
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic [IDX_W-1:0] core_char;
  logic             core_valid;
  logic [IDX_W-1:0] core_result;
  logic             core_res_valid;
  logic [7:0]       tx_byte;
  logic             tx_start;
  logic             tx_done;

  modport master (
    output rx_byte, rx_valid, core_result, core_res_valid, tx_done,
    input  core_char, core_valid, tx_byte, tx_start
  );

  modport slave (
    input  rx_byte, rx_valid, core_result, core_res_valid, tx_done,
    output core_char, core_valid, tx_byte, tx_start
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with sync clear
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over push/pop
//   push/wdata : write request; ignored when full (full sampled before pop)
//   pop        : read request; ignored when empty
//   rdata      : head word, valid whenever empty is low
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/enigma_stream_bridge.sv
// rtl/enigma_stream_bridge.sv - buffered, order-preserving UART <-> Enigma core byte bridge
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : rx_byte/rx_valid in, core_char/core_valid out,
//                  core_result/core_res_valid in, tx_byte/tx_start out, tx_done in
//   flush        : synchronous clear of FIFOs, FSMs and status
//   overflow     : sticky, an rx byte was dropped on a full input FIFO
//   timeout_err  : sticky, the core did not answer within CORE_TIMEOUT cycles
//   drop_count   : saturating count of dropped rx bytes
module enigma_stream_bridge
  import enigma_pkg::*;
#(
  parameter int IN_DEPTH      = 16,
  parameter int OUT_DEPTH     = 16,
  parameter bit PASS_NONALPHA = 1'b1,
  parameter bit KEEP_CASE     = 1'b1,
  parameter int CORE_TIMEOUT  = 64,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  enigma_stream_bridge_if.slave  bus,
  input  logic                   flush,
  output logic                   overflow,
  output logic                   timeout_err,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int TMR_W = $clog2(CORE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(CORE_TIMEOUT);

  // FIFO plumbing
  logic [7:0] in_data;
  logic       in_full;
  logic       in_empty;
  logic       in_pop;
  logic       out_push;
  logic [7:0] out_wdata;
  logic [7:0] out_data;
  logic       out_full;
  logic       out_empty;
  logic       out_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (flush),
    .push  (bus.rx_valid),
    .wdata (bus.rx_byte),
    .pop   (in_pop),
    .rdata (in_data),
    .full  (in_full),
    .empty (in_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (flush),
    .push  (out_push),
    .wdata (out_wdata),
    .pop   (out_pop),
    .rdata (out_data),
    .full  (out_full),
    .empty (out_empty)
  );

  // Cipher FSM
  cipher_state_e    c_state;
  cipher_state_e    c_next;
  logic [TMR_W-1:0] timer;
  logic             lower_q;
  logic [IDX_W-1:0] core_char_q;
  logic             core_valid_q;
  char_class_e      head_cls;
  logic             can_take;
  logic             core_fire;
  logic             tmo_fire;
  logic [7:0]       head_off;
  logic [7:0]       res_base;

  assign head_cls = classify(in_data);
  // Taking a byte only when the out-FIFO has room guarantees the eventual
  // core result always has a slot, so WAIT never has to stall on a push.
  assign can_take = !in_empty && !out_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_state      <= C_IDLE;
      timer        <= '0;
      lower_q      <= 1'b0;
      core_char_q  <= '0;
      core_valid_q <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (flush) begin
      c_state      <= C_IDLE;
      timer        <= '0;
      lower_q      <= 1'b0;
      core_char_q  <= '0;
      core_valid_q <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      c_state      <= c_next;
      core_valid_q <= core_fire;
      if (core_fire) begin
        core_char_q <= IDX_W'(head_off);
        lower_q     <= (head_cls == CLS_LOWER);
        timer       <= '0;
      end else if (c_state == C_WAIT) begin
        timer <= timer + 1'b1;
      end
      if (tmo_fire) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    c_next = c_state;
    case (c_state)
      C_IDLE: if (can_take && head_cls != CLS_OTHER) c_next = C_WAIT;
      C_WAIT: if (bus.core_res_valid || timer == TMR_LIMIT) c_next = C_IDLE;
      default: c_next = C_IDLE;
    endcase
  end

  always_comb begin
    in_pop    = 1'b0;
    out_push  = 1'b0;
    out_wdata = in_data;
    core_fire = 1'b0;
    tmo_fire  = 1'b0;
    head_off  = (head_cls == CLS_LOWER) ? (in_data - ASCII_a) : (in_data - ASCII_A);
    res_base  = (lower_q && KEEP_CASE) ? ASCII_a : ASCII_A;
    case (c_state)
      C_IDLE: begin
        if (can_take) begin
          in_pop = 1'b1;
          if (head_cls == CLS_OTHER) out_push = PASS_NONALPHA;
          else                       core_fire = 1'b1;
        end
      end
      C_WAIT: begin
        if (bus.core_res_valid) begin
          out_push  = 1'b1;
          out_wdata = {{(8-IDX_W){1'b0}}, bus.core_result} + res_base;
        end else if (timer == TMR_LIMIT) begin
          tmo_fire = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // TX FSM
  tx_state_e  t_state;
  tx_state_e  t_next;
  logic [7:0] tx_byte_q;
  logic       tx_start_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_state    <= T_IDLE;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
    end else if (flush) begin
      // tx_byte is left as-is so a byte already on the wire stays stable.
      t_state    <= T_IDLE;
      tx_start_q <= 1'b0;
    end else begin
      t_state    <= t_next;
      tx_start_q <= out_pop;
      if (out_pop) tx_byte_q <= out_data;
    end
  end

  always_comb begin
    t_next = t_state;
    case (t_state)
      T_IDLE:  if (!out_empty) t_next = T_BUSY;
      T_BUSY:  if (bus.tx_done) t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  always_comb begin
    out_pop = (t_state == T_IDLE) && !out_empty;
  end

  // RX drop status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (bus.rx_valid && in_full) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + 1'b1;
    end
  end

  assign bus.core_char  = core_char_q;
  assign bus.core_valid = core_valid_q;
  assign bus.tx_byte    = tx_byte_q;
  assign bus.tx_start   = tx_start_q;

endmodule

// File: tb/tb_enigma_stream_bridge.sv
// tb/tb_enigma_stream_bridge.sv - directed self-checking bench for enigma_stream_bridge
//   Three bridges: u[0] defaults, u[1] KEEP_CASE=0, u[2] PASS_NONALPHA=0.
//   Each has a stub core ((idx+1)%26, 3-cycle latency) and stub UART TX (done 20 cycles after start).
module tb_enigma_stream_bridge;
  import enigma_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_byte  = 8'h00;
  logic       rx_valid = 1'b0;
  int         rx_sel   = 0;
  logic [2:0] rst_v    = 3'b000;
  logic [2:0] flush_v  = 3'b000;
  logic [2:0] hold_v   = 3'b000;
  logic [2:0] silent_v = 3'b000;

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : u
    enigma_stream_bridge_if bus ();
    logic       overflow;
    logic       timeout_err;
    logic [7:0] drop_count;

    enigma_stream_bridge #(
      .IN_DEPTH      (16),
      .OUT_DEPTH     (16),
      .PASS_NONALPHA ((g == 2) ? 1'b0 : 1'b1),
      .KEEP_CASE     ((g == 1) ? 1'b0 : 1'b1),
      .CORE_TIMEOUT  (64),
      .CNT_W         (8)
    ) dut (
      .clk         (clk),
      .reset_n     (rst_v[g]),
      .bus         (bus),
      .flush       (flush_v[g]),
      .overflow    (overflow),
      .timeout_err (timeout_err),
      .drop_count  (drop_count)
    );

    assign bus.rx_byte  = rx_byte;
    assign bus.rx_valid = rx_valid && (rx_sel == g);

    logic       d1 = 1'b0, d2 = 1'b0, res_v = 1'b0;
    logic [4:0] i1 = '0, i2 = '0, res_q = '0;
    int         core_cnt = 0;

    always @(posedge clk) begin
      d1    <= bus.core_valid && !silent_v[g];
      i1    <= 5'((int'(bus.core_char) + 1) % ALPHA_N);
      d2    <= d1;
      i2    <= i1;
      res_v <= d2;
      res_q <= i2;
      if (bus.core_valid) core_cnt <= core_cnt + 1;
    end

    assign bus.core_res_valid = res_v;
    assign bus.core_result    = res_q;

    logic       busy = 1'b0, done_q = 1'b0;
    int         tcnt = 0;
    int         tx_cnt = 0;
    logic [7:0] tx_log [128];

    always @(posedge clk) begin
      done_q <= 1'b0;
      if (bus.tx_start) begin
        busy <= 1'b1;
        tcnt <= 0;
        if (tx_cnt < 128) tx_log[tx_cnt] <= bus.tx_byte;
        tx_cnt <= tx_cnt + 1;
      end else if (busy) begin
        tcnt <= tcnt + 1;
        if (tcnt >= 19 && !hold_v[g]) begin
          busy   <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end

    assign bus.tx_done = done_q;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int tx_cnt_of(input int g);
    case (g)
      0:       return u[0].tx_cnt;
      1:       return u[1].tx_cnt;
      default: return u[2].tx_cnt;
    endcase
  endfunction

  function automatic logic [7:0] log_of(input int g, input int i);
    case (g)
      0:       return u[0].tx_log[i];
      1:       return u[1].tx_log[i];
      default: return u[2].tx_log[i];
    endcase
  endfunction

  task automatic send(input int sel, input logic [7:0] b);
    rx_sel   = sel;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int g, input int n, input int budget);
    int k = 0;
    while (tx_cnt_of(g) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (tx_cnt_of(g) < n) check($sformatf("wait_tx_u%0d", g), tx_cnt_of(g), n);
  endtask

  initial begin
    int base;
    int nonspace;

    repeat (3) @(negedge clk);
    check("rst_core_valid", u[0].bus.core_valid, 0);
    check("rst_core_char",  u[0].bus.core_char, 0);
    check("rst_tx_start",   u[0].bus.tx_start, 0);
    check("rst_tx_byte",    u[0].bus.tx_byte, 0);
    check("rst_overflow",   u[0].overflow, 0);
    check("rst_timeout",    u[0].timeout_err, 0);
    check("rst_drop",       u[0].drop_count, 0);
    rst_v = 3'b111;
    @(negedge clk);

    // 1: "aB " -> "bC ", with core_valid latency of 2
    rx_sel = 0; rx_byte = "a"; rx_valid = 1'b1;
    @(negedge clk);
    check("t1_lat_c1", u[0].bus.core_valid, 0);
    rx_byte = "B";
    @(negedge clk);
    check("t1_lat_c2", u[0].bus.core_valid, 1);
    check("t1_core_char", u[0].bus.core_char, 0);
    rx_byte = " ";
    @(negedge clk);
    rx_valid = 1'b0;
    wait_tx(0, 3, 300);
    check("t1_byte0", log_of(0, 0), "b");
    check("t1_byte1", log_of(0, 1), "C");
    check("t1_byte2", log_of(0, 2), " ");
    repeat (60) @(negedge clk);
    check("t1_tx_count", tx_cnt_of(0), 3);

    // pass-through latency: tx_start on cycle 3
    send(0, "-");
    @(negedge clk);
    check("pt_lat_c2", u[0].bus.tx_start, 0);
    @(negedge clk);
    check("pt_lat_c3", u[0].bus.tx_start, 1);
    check("pt_byte", u[0].bus.tx_byte, "-");

    // 2: KEEP_CASE=0, "z" -> 25 -> "A"
    send(1, "z");
    @(negedge clk);
    check("t2_core_valid", u[1].bus.core_valid, 1);
    check("t2_core_char", u[1].bus.core_char, 25);
    wait_tx(1, 1, 300);
    check("t2_byte", log_of(1, 0), "A");

    // 3: PASS_NONALPHA=0, "A" CR "B" -> "BC"
    send(2, "A");
    send(2, 8'h0D);
    send(2, "B");
    wait_tx(2, 2, 300);
    repeat (40) @(negedge clk);
    check("t3_core_reqs", u[2].core_cnt, 2);
    check("t3_tx_count", tx_cnt_of(2), 2);
    check("t3_byte0", log_of(2, 0), "B");
    check("t3_byte1", log_of(2, 1), "C");

    // 4: back-pressure, 40 spaces with tx_done withheld
    base = tx_cnt_of(0);
    hold_v[0] = 1'b1;
    for (int i = 0; i < 40; i++) send(0, " ");
    repeat (5) @(negedge clk);
    check("t4_drop_count", u[0].drop_count, 7);
    check("t4_overflow", u[0].overflow, 1);
    hold_v[0] = 1'b0;
    wait_tx(0, base + 33, 2000);
    repeat (60) @(negedge clk);
    check("t4_sent", tx_cnt_of(0) - base, 33);
    nonspace = 0;
    for (int i = 0; i < 33; i++) if (log_of(0, base + i) != " ") nonspace++;
    check("t4_all_spaces", nonspace, 0);

    flush_v[0] = 1'b1;
    @(negedge clk);
    flush_v[0] = 1'b0;
    check("flush_overflow", u[0].overflow, 0);
    check("flush_drop", u[0].drop_count, 0);

    // 5: silent core -> timeout after CORE_TIMEOUT, then recovery
    silent_v[0] = 1'b1;
    rx_sel = 0; rx_byte = "Q"; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (65) @(negedge clk);
    check("t5_no_timeout_yet", u[0].timeout_err, 0);
    @(negedge clk);
    check("t5_timeout", u[0].timeout_err, 1);
    silent_v[0] = 1'b0;
    base = tx_cnt_of(0);
    send(0, "A");
    wait_tx(0, base + 1, 300);
    check("t5_recover", log_of(0, base), "B");

    // 6: reset while waiting on the core
    repeat (40) @(negedge clk);
    base = tx_cnt_of(0);
    send(0, "C");
    @(negedge clk);
    check("t6_in_wait", u[0].bus.core_valid, 1);
    rst_v[0] = 1'b0;
    #1;
    check("t6_core_valid", u[0].bus.core_valid, 0);
    check("t6_core_char", u[0].bus.core_char, 0);
    check("t6_tx_byte", u[0].bus.tx_byte, 0);
    check("t6_tx_start", u[0].bus.tx_start, 0);
    check("t6_timeout", u[0].timeout_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 1'b1;
    repeat (80) @(negedge clk);
    check("t6_no_late_tx", tx_cnt_of(0), base);
    send(0, "A");
    wait_tx(0, base + 1, 300);
    check("t6_after_reset", log_of(0, base), "B");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
